// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between an instruction-fetch
// read port and a data read/write port; fixed-length access with a write-hold cycle.
module sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk_in_50M,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ack,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_dq_o,
  output logic                  sram_dq_oe,
  input  logic [DATA_W-1:0]     sram_dq_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [DATA_W/8-1:0]   sram_be_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                state, state_next;
  logic [3:0]            wait_cnt, wait_cnt_next;
  logic                  last_data, last_data_next;
  logic                  grant_data, grant_data_next;
  logic                  is_write, is_write_next;
  logic [DATA_W-1:0]     i_rdata_next, d_rdata_next;
  logic                  i_ack_next, d_ack_next;
  logic [ADDR_W-1:0]     sram_addr_next;
  logic [DATA_W-1:0]     sram_dq_o_next;
  logic                  sram_dq_oe_next, sram_ce_n_next, sram_oe_n_next, sram_we_n_next;
  logic [DATA_W/8-1:0]   sram_be_n_next;
  logic                  pick_data, pick_write;

  // Data port wins unless the instruction port also asks and data was served last.
  assign pick_data  = d_req && (!i_req || !last_data);
  assign pick_write = pick_data && d_we;

  always_ff @(posedge clk_in_50M or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      last_data  <= 1'b0;
      grant_data <= 1'b0;
      is_write   <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= '1;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      last_data  <= last_data_next;
      grant_data <= grant_data_next;
      is_write   <= is_write_next;
      i_rdata    <= i_rdata_next;
      d_rdata    <= d_rdata_next;
      i_ack      <= i_ack_next;
      d_ack      <= d_ack_next;
      sram_addr  <= sram_addr_next;
      sram_dq_o  <= sram_dq_o_next;
      sram_dq_oe <= sram_dq_oe_next;
      sram_ce_n  <= sram_ce_n_next;
      sram_oe_n  <= sram_oe_n_next;
      sram_we_n  <= sram_we_n_next;
      sram_be_n  <= sram_be_n_next;
    end
  end

  always_comb begin
    state_next      = state;
    wait_cnt_next   = wait_cnt;
    last_data_next  = last_data;
    grant_data_next = grant_data;
    is_write_next   = is_write;
    i_rdata_next    = i_rdata;
    d_rdata_next    = d_rdata;
    i_ack_next      = 1'b0;
    d_ack_next      = 1'b0;
    sram_addr_next  = sram_addr;
    sram_dq_o_next  = sram_dq_o;
    sram_dq_oe_next = sram_dq_oe;
    sram_ce_n_next  = sram_ce_n;
    sram_oe_n_next  = sram_oe_n;
    sram_we_n_next  = sram_we_n;
    sram_be_n_next  = sram_be_n;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant_data_next = pick_data;
          last_data_next  = pick_data;
          is_write_next   = pick_write;
          sram_addr_next  = pick_data ? d_addr : i_addr;
          if (pick_write) sram_dq_o_next = d_wdata;
          sram_dq_oe_next = pick_write;
          sram_ce_n_next  = 1'b0;
          sram_oe_n_next  = pick_write;
          sram_we_n_next  = !pick_write;
          sram_be_n_next  = pick_write ? ~d_be : '0;
          wait_cnt_next   = WAIT_LOAD;
          state_next      = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_cnt == 4'd0) begin
          if (!is_write) begin
            if (grant_data) d_rdata_next = sram_dq_i;
            else            i_rdata_next = sram_dq_i;
          end
          i_ack_next     = !grant_data;
          d_ack_next     = grant_data;
          sram_oe_n_next = 1'b1;
          sram_we_n_next = 1'b1;
          state_next     = DONE;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      DONE: begin
        // Address, data and chip enable were held one extra cycle for write hold time.
        sram_ce_n_next  = 1'b1;
        sram_dq_oe_next = 1'b0;
        sram_be_n_next  = '1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
